uart_boot_loader: RTL and testbench

Program loader feeding the multicycle CPU's instruction memory over UART. It sits between the `uart_rx`/`uart_tx` pair and the instruction RAM write port. It consumes the host's byte stream (length header, then instruction words) and writes each assembled word to consecutive word addresses. It replies with a status byte and raises `load_done`, which the top level uses to hold the CPU in reset until the program is in memory.

---
 rtl/uart_boot_loader_if.sv | 22 ++
 rtl/uart_boot_loader.sv | 96 +++++++++
 tb/tb_uart_boot_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: byte stream, status handshake and instruction RAM write port of the boot loader.
interface uart_boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_ferr;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        load_done;
  logic        load_error;
  modport master (
    input  rx_data, rx_ready, rx_ferr, tx_busy,
    output tx_data, tx_start, imem_we, imem_addr, imem_wdata, load_done, load_error
  );
  modport slave (
    output rx_data, rx_ready, rx_ferr, tx_busy,
    input  tx_data, tx_start, imem_we, imem_addr, imem_wdata, load_done, load_error
  );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a big-endian length plus instruction words over UART, writes them to imem, replies ACK/NAK.
module uart_boot_loader #(
  parameter int         MAX_WORDS = 32768,
  parameter logic [7:0] ACK_BYTE  = 8'hAA,
  parameter logic [7:0] NAK_BYTE  = 8'h55
) (
  input logic                clk,
  input logic                rst,
  uart_boot_loader_if.master bus
);
  typedef enum logic [2:0] {LEN, DATA, WRITE, STATUS, DONE, ERR} state_t;
  state_t      state;
  logic [31:0] len, idx, word;
  logic [31:0] len_nxt, word_nxt, idx_nxt;
  logic [1:0]  cnt;
  logic        nak_sent;
  assign len_nxt  = {len[23:0], bus.rx_data};
  assign word_nxt = {word[23:0], bus.rx_data};
  assign idx_nxt  = idx + 32'd1;
  // word is the assembly shift register so imem_wdata only changes on a write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= LEN;
      len            <= '0;
      idx            <= '0;
      word           <= '0;
      cnt            <= '0;
      nak_sent       <= 1'b0;
      bus.tx_data    <= '0;
      bus.tx_start   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.load_done  <= 1'b0;
      bus.load_error <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      bus.imem_we  <= 1'b0;
      case (state)
        LEN:
          if (bus.rx_ferr) state <= ERR;
          else if (bus.rx_ready) begin
            len <= len_nxt;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (len_nxt == '0) begin
                bus.tx_data  <= ACK_BYTE;
                bus.tx_start <= !bus.tx_busy;
                state        <= bus.tx_busy ? STATUS : DONE;
              end else state <= (len_nxt > 32'(MAX_WORDS)) ? ERR : DATA;
            end
          end
        DATA:
          if (bus.rx_ferr) state <= ERR;
          else if (bus.rx_ready) begin
            word <= word_nxt;
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= idx;
              bus.imem_wdata <= word_nxt;
              state          <= WRITE;
            end
          end
        WRITE: begin
          idx <= idx_nxt;
          if (bus.rx_ferr) state <= ERR;
          else if (idx_nxt == len) begin
            bus.tx_data  <= ACK_BYTE;
            bus.tx_start <= !bus.tx_busy;
            state        <= bus.tx_busy ? STATUS : DONE;
          end else begin
            // a byte arriving during the write starts the next word
            state <= DATA;
            cnt   <= {1'b0, bus.rx_ready};
            if (bus.rx_ready) word <= word_nxt;
          end
        end
        STATUS:
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            state        <= DONE;
          end
        DONE: bus.load_done <= 1'b1;
        ERR: begin
          bus.load_error <= 1'b1;
          if (!nak_sent && !bus.tx_busy) begin
            bus.tx_data  <= NAK_BYTE;
            bus.tx_start <= 1'b1;
            nak_sent     <= 1'b1;
          end
        end
        default: state <= LEN;
      endcase
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed byte streams with a write/status scoreboard checked by an independent monitor.
module tb_uart_boot_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int tx_cnt = 0;
  logic [63:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic prev_we = 1'b0;
  logic ack_pend = 1'b0;
  uart_boot_loader_if bus();
  uart_boot_loader dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      prev_we  = 1'b0;
      ack_pend = 1'b0;
    end else begin
      if (ack_pend) chk("load_done_after_ack", 64'(bus.load_done), 64'd1);
      ack_pend = 1'b0;
      if (bus.imem_we) begin
        chk("we_not_back_to_back", 64'(prev_we), 64'd0);
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.imem_addr, bus.imem_wdata);
        end else chk("imem_write", {bus.imem_addr, bus.imem_wdata}, exp_wr.pop_front());
      end
      if (bus.tx_start) begin
        tx_cnt++;
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got %0h expected no status", bus.tx_data);
        end else begin
          chk("tx_status", 64'(bus.tx_data), 64'(exp_tx[0]));
          ack_pend = (exp_tx.pop_front() == 8'hAA);
        end
      end
      prev_we = bus.imem_we;
    end
  end
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
    chk("rst_tx_start", 64'(bus.tx_start), 64'd0);
    chk("rst_imem_we", 64'(bus.imem_we), 64'd0);
    chk("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("rst_load_done", 64'(bus.load_done), 64'd0);
    chk("rst_load_error", 64'(bus.load_error), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
  endtask
  task automatic send(logic [7:0] b, int gap, logic ferr = 1'b0);
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    bus.rx_ferr  = ferr;
    @(posedge clk); #1;
    bus.rx_ready = 1'b0;
    bus.rx_ferr  = 1'b0;
    repeat (gap) @(posedge clk);
  endtask
  task automatic send_word(logic [31:0] w, int gap);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8], gap);
  endtask
  task automatic end_test(logic done, logic err);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("load_done", 64'(bus.load_done), 64'(done));
    chk("load_error", 64'(bus.load_error), 64'(err));
    chk("writes_outstanding", 64'(exp_wr.size()), 64'd0);
    chk("status_outstanding", 64'(exp_tx.size()), 64'd0);
    exp_wr.delete();
    exp_tx.delete();
  endtask
  initial begin
    int t0;
    bus.rx_data  = '0;
    bus.rx_ready = 1'b0;
    bus.rx_ferr  = 1'b0;
    bus.tx_busy  = 1'b0;
    do_reset();
    // two-word load, bytes every 2 cycles, latency checks
    exp_wr.push_back({32'd0, 32'h12345678});
    exp_wr.push_back({32'd1, 32'h9ABCDEF0});
    exp_tx.push_back(8'hAA);
    send_word(32'd2, 0);
    send_word(32'h12345678, 0);
    @(negedge clk) chk("we_latency", 64'(bus.imem_we), 64'd1);
    send_word(32'h9ABCDEF0, 0);
    @(negedge clk);
    @(negedge clk) chk("ack_latency", 64'(bus.tx_start), 64'd1);
    end_test(1'b1, 1'b0);
    // zero length
    do_reset();
    exp_tx.push_back(8'hAA);
    send_word(32'd0, 0);
    @(negedge clk) chk("len0_ack_latency", 64'(bus.tx_start), 64'd1);
    end_test(1'b1, 1'b0);
    // oversize length, trailing bytes ignored
    do_reset();
    exp_tx.push_back(8'h55);
    t0 = tx_cnt;
    send_word(32'd32769, 0);
    send_word(32'h11223344, 0);
    end_test(1'b0, 1'b1);
    chk("nak_once", 64'(tx_cnt - t0), 64'd1);
    // framing error on 3rd byte of word 1
    do_reset();
    exp_wr.push_back({32'd0, 32'hCAFEBABE});
    exp_tx.push_back(8'h55);
    send_word(32'd2, 0);
    send_word(32'hCAFEBABE, 0);
    send(8'hDE, 0);
    send(8'hAD, 0);
    send(8'hBE, 0, 1'b1);
    send(8'hEF, 0);
    end_test(1'b0, 1'b1);
    // tx_busy held while the load finishes
    do_reset();
    bus.tx_busy = 1'b1;
    exp_wr.push_back({32'd0, 32'h01020304});
    exp_tx.push_back(8'hAA);
    t0 = tx_cnt;
    send_word(32'd1, 0);
    send_word(32'h01020304, 0);
    repeat (50) @(posedge clk);
    chk("no_tx_while_busy", 64'(tx_cnt - t0), 64'd0);
    #1 bus.tx_busy = 1'b0;
    @(negedge clk) chk("tx_wait_edge", 64'(bus.tx_start), 64'd0);
    @(negedge clk) chk("tx_after_busy", 64'(bus.tx_start), 64'd1);
    send_word(32'h55667788, 0);
    end_test(1'b1, 1'b0);
    // reset mid-load then a fresh stream
    do_reset();
    exp_wr.push_back({32'd0, 32'h11223344});
    send_word(32'd2, 3);
    send_word(32'h11223344, 3);
    send(8'h55, 3);
    do_reset();
    exp_wr.push_back({32'd0, 32'hAABBCCDD});
    exp_tx.push_back(8'hAA);
    send_word(32'd1, 3);
    send_word(32'hAABBCCDD, 3);
    end_test(1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
